ysyx_22040383_wb_stage: RTL

Registered, parametrised write-back stage for the five-stage pipeline. Holds one instruction received from MEM behind a valid/ready handshake. Aligns and sign/zero-extends load data, selects between the ALU result and load data, and drives the register-file write port. Also provides a bypass copy for forwarding, suppresses writes to x0, and counts retired instructions.

---
 rtl/ysyx_22040383_wb_stage.sv | 95 +++++++++
 1 files changed

// File: rtl/ysyx_22040383_wb_stage.sv
// Write-back stage: one registered entry from MEM, load alignment/extension,
// register-file write port, forwarding bypass and retired-instruction counter.
module ysyx_22040383_wb_stage #(
  parameter int XLEN  = 64,
  parameter int RF_AW = 5,
  parameter int CNT_W = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_alu_data,
  input  logic [XLEN-1:0]              in_mem_data,
  input  logic [$clog2(XLEN/8)-1:0]    in_mem_addr_lo,
  input  logic                         in_is_load,
  input  logic [1:0]                   in_mem_size,
  input  logic                         in_mem_unsigned,
  input  logic [RF_AW-1:0]             in_rd,
  input  logic                         in_rf_we,
  input  logic                         flush,
  input  logic                         stall,
  output logic                         rf_we,
  output logic [RF_AW-1:0]             rf_waddr,
  output logic [XLEN-1:0]              rf_wdata,
  output logic                         byp_valid,
  output logic [RF_AW-1:0]             byp_rd,
  output logic [XLEN-1:0]              byp_data,
  output logic                         commit,
  output logic [CNT_W-1:0]             instret
);

  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } ent_t;

  logic            valid_q;
  ent_t            ent_q;
  logic            cap;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ld_data;
  logic            top_bit;
  int              keep;

  assign in_ready = !valid_q || !stall;
  assign cap      = in_valid && in_ready && !flush;

  // Misaligned offset/size pairs are not trapped: the right shift zero-fills
  // and the kept field is extended as-is.
  always_comb begin
    shifted = in_mem_data >> {in_mem_addr_lo, 3'b000};
    keep    = XLEN;
    top_bit = shifted[XLEN-1];
    ld_data = '0;
    case (in_mem_size)
      2'd0: begin keep = 8;  top_bit = shifted[7];  end
      2'd1: begin keep = 16; top_bit = shifted[15]; end
      2'd2: begin keep = 32; top_bit = shifted[31]; end
      default: ;
    endcase
    for (int i = 0; i < XLEN; i++)
      ld_data[i] = (i < keep) ? shifted[i] : (top_bit & !in_mem_unsigned);
  end

  assign rf_we     = valid_q && ent_q.we && !stall;
  assign rf_waddr  = ent_q.rd;
  assign rf_wdata  = ent_q.data;
  // Bypass ignores stall so consumers see the pending value while it is held.
  assign byp_valid = valid_q && ent_q.we;
  assign byp_rd    = ent_q.rd;
  assign byp_data  = ent_q.data;
  assign commit    = valid_q && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
      instret <= '0;
    end else begin
      if (commit) instret <= instret + CNT_W'(1);
      if (flush) begin
        valid_q <= 1'b0;
      end else if (cap) begin
        valid_q    <= 1'b1;
        ent_q.we   <= in_rf_we && (in_rd != '0);
        ent_q.rd   <= in_rd;
        ent_q.data <= in_is_load ? ld_data : in_alu_data;
      end else if (commit) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
